arb_req_queue: RTL and testbench
================================

// Module: arb_req_queue
// PURPOSE
//  Upstream feeder for the 4-way round-robin arbiter. Holds one small FIFO per requester.
//  Drives the arbiter's req[3:0] from FIFO non-empty status. Pops the head of FIFO i when
//  the arbiter's registered one-hot grant[i] arrives, and presents it as a single
//  registered output beat tagged with the requester id.
// PARAMETERS
//  DW     32  payload width per entry, in bits
//  DEPTH  4   entries per requester FIFO; power of two, >= 2
//  CW     16  width of each per-requester pop counter (ARBQ_STATS_EN only)
// PORTS
//  clk        in   1      single clock; all logic is rising-edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   4      per-requester push valid
//  in_data    in   4*DW   per-requester push data; requester i uses [i*DW +: DW]
//  in_ready   out  4      per-requester push ready; high when that FIFO is not full
//  req        out  4      to arbiter; req[i] = FIFO i non-empty
//  grant      in   4      from arbiter; registered, one-hot or zero
//  out_valid  out  1      one-cycle pulse; out_data/out_id are valid
//  out_data   out  DW     popped payload
//  out_id     out  2      index of the requester that was popped
//  err_grant  out  1      sticky error flag; cleared only by rst
//  pop_cnt    out  4*CW   per-requester pop counters (ARBQ_STATS_EN only)
// BEHAVIOUR
//  - Reset: all FIFOs empty; req=0, in_ready=4'hF, out_valid=0, out_data=0, out_id=0,
//    err_grant=0, pop_cnt=0. Reset mid-operation discards all queued entries, and any
//    grant arriving in the reset cycle is ignored.
//  - Push: a push occurs when in_valid[i] && in_ready[i]. The data is written at the
//    tail; count[i] increments at the clock edge.
//  - in_ready[i] = (count[i] != DEPTH). It does not look ahead to a same-cycle pop,
//    so a full FIFO refuses a push even in a cycle where it is being popped.
//  - req[i] = (count[i] != 0), taken from registered count.
//    A push in cycle t raises req in cycle t+1.
//  - Pop: when grant is one-hot with grant[i]=1 and count[i]!=0, the head of FIFO i
//    is read and the read pointer advances. In cycle t+1: out_valid=1,
//    out_data=head, out_id=i.
//  - A push and a pop on the same FIFO in the same cycle: count is unchanged and
//    both pointers advance.
//  - Pointers are AW=$clog2(DEPTH) bits wide and wrap modulo DEPTH.
//    count is AW+1 bits wide.
//  - Grant to an empty FIFO: no pop, out_valid=0 next cycle, err_grant set.
//  - Grant not one-hot (more than one bit set): no pop for any requester, err_grant set.
//  - Grant of zero: no action; out_valid=0 next cycle.
//  - A single-entry FIFO granted in cycle t keeps req high until t+1. The arbiter
//    masks back-to-back grants to the same requester, so no grant to an empty FIFO
//    occurs in normal use.
//  - Throughput: at most one pop per cycle in total. The arbiter limits each
//    requester to one grant every other cycle.
// CONFIGURATION
//  - ARBQ_STATS_EN defined: the pop_cnt port exists.
//    pop_cnt[i] increments by 1 on every pop from FIFO i and wraps at 2^CW.
//    It is cleared by rst.
//  - ARBQ_STATS_EN undefined: the pop_cnt port and its counters are absent.
//    CW is unused.
// STRUCTURE
//  - Shared package arbq_pkg holds:
//    - NREQ=4 and ID_W=2;
//    - typedef arbq_beat_t {data, id};
//    - function onehot4() used for the grant check.
//  - One sub-module, arbq_fifo (parameters DW, DEPTH; ports push, push_data, pop,
//    head, full, empty), instantiated 4x via generate.
//  - Top level contains: grant decode, one-hot check, output register, err_grant,
//    and the optional stats counters.
// TESTING
//  1. Reset, then a single push on requester 2 (data 0xA5A5_0002): req=4'b0100 next
//     cycle; drive grant=4'b0100 -> next cycle out_valid=1, out_data=0xA5A5_0002,
//     out_id=2; req=0 after.
//  2. Push DEPTH=4 entries into requester 0: in_ready[0]=0 after the 4th push; a 5th
//     push is refused. Popping all four returns them in push order; in_ready[0]
//     returns to 1 after the first pop.
//  3. Requester 1 full, in_valid[1]=1 and grant=4'b0010 in the same cycle: push
//     refused, one pop occurs, count becomes 3.
//  4. Requester 3 holding 2 entries, push and pop in the same cycle, 8 times:
//     count stays 2; outputs remain in FIFO order across pointer wrap.
//  5. grant=4'b0001 with FIFO 0 empty -> no out_valid, err_grant=1. grant=4'b0011
//     -> no pops, err_grant stays 1. Assert rst -> err_grant=0 and all FIFOs empty.
//  6. ARBQ_STATS_EN build: 5 pops from requester 1 and 2 from requester 3 give
//     pop_cnt[1]=5, pop_cnt[3]=2, others 0. A build without the macro compiles
//     without the pop_cnt port.

Source files
------------

// File: rtl/arbq_pkg.sv
// Shared definitions for the arbiter request queue: requester count, output beat type
// and the grant one-hot check.
package arbq_pkg;

  localparam int NREQ        = 4;
  localparam int ID_W        = 2;
  localparam int ARBQ_DW_MAX = 32;

  // Payload narrower than ARBQ_DW_MAX is zero-extended into the data field.
  typedef struct packed {
    logic [ARBQ_DW_MAX-1:0] data;
    logic [ID_W-1:0]        id;
  } arbq_beat_t;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/arbq_fifo.sv
// Per-requester FIFO with pointer-based storage and an occupancy count.
// A push on a full FIFO or a pop on an empty FIFO must be blocked by the caller.
module arbq_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Storage is not reset: stale entries are never visible once the count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/arb_req_queue.sv
// Upstream feeder for the 4-way round-robin arbiter: per-requester FIFOs, grant-driven pop,
// registered output beat and sticky grant error. ARBQ_STATS_EN adds per-requester pop counters.
module arb_req_queue
  import arbq_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
`ifdef ARBQ_STATS_EN
  ,
  parameter int CW    = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      req,
  input  logic [3:0]      grant,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic            err_grant
`ifdef ARBQ_STATS_EN
  ,
  output logic [4*CW-1:0] pop_cnt
`endif
);

  logic [NREQ-1:0] w_full;
  logic [NREQ-1:0] w_empty;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic [DW-1:0]   w_head [NREQ];
  logic            w_onehot;
  logic            w_bad_grant;
  arbq_beat_t      w_beat;

  logic            r_valid;
  arbq_beat_t      r_beat;
  logic            r_err;

  assign w_push = in_valid & ~w_full;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    arbq_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push[gi]),
      .push_data (in_data[gi*DW +: DW]),
      .pop       (w_pop[gi]),
      .head      (w_head[gi]),
      .full      (w_full[gi]),
      .empty     (w_empty[gi])
    );
  end

  // A malformed grant pops nothing; a well-formed grant to an empty FIFO is only flagged.
  assign w_onehot    = onehot4(grant);
  assign w_pop       = w_onehot ? (grant & ~w_empty) : '0;
  assign w_bad_grant = (grant != '0) && (!w_onehot || ((grant & w_empty) != '0));

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pop[i]) begin
        w_beat.data = ARBQ_DW_MAX'(w_head[i]);
        w_beat.id   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= |w_pop;
      if (|w_pop) begin
        r_beat <= w_beat;
      end
      if (w_bad_grant) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready  = ~w_full;
  assign req       = ~w_empty;
  assign out_valid = r_valid;
  assign out_data  = r_beat.data[DW-1:0];
  assign out_id    = r_beat.id;
  assign err_grant = r_err;

`ifdef ARBQ_STATS_EN
  logic [CW-1:0] r_pop_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_pop_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_pop[i]) begin
          r_pop_cnt[i] <= r_pop_cnt[i] + CW'(1);
        end
      end
    end
  end

  for (genvar gc = 0; gc < NREQ; gc++) begin : g_cnt
    assign pop_cnt[gc*CW +: CW] = r_pop_cnt[gc];
  end
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: stimulus pushes expected beats, a negedge monitor
// checks every output beat. Pop counters are checked when ARBQ_STATS_EN is defined.
module tb_arb_req_queue;

  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            err_grant;
`ifdef ARBQ_STATS_EN
  logic [63:0]     pop_cnt;
`endif

  exp_t sbq[$];
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  arb_req_queue #(
    .DW    (DW),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .err_grant (err_grant)
`ifdef ARBQ_STATS_EN
    ,
    .pop_cnt   (pop_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] slot(input int idx, input logic [DW-1:0] d);
    logic [4*DW-1:0] v;
    v = '0;
    v[idx*DW +: DW] = d;
    return v;
  endfunction

  // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
  task automatic applyStimulus(input logic [3:0] v, input logic [4*DW-1:0] d, input logic [3:0] g);
    in_valid = v;
    in_data  = d;
    grant    = g;
    @(posedge clk);
    #1;
    in_valid = '0;
    in_data  = '0;
    grant    = '0;
  endtask

  task automatic expectPop(input int idx, input logic [31:0] d);
    sbq.push_back('{data: d, id: 2'(idx)});
    applyStimulus(4'b0000, '0, 4'(1 << idx));
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_beat", {30'd0, out_id, out_data}, 64'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("beat", {30'd0, out_id, out_data}, {30'd0, e.id, e.data});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    grant    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_req", 64'(req), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'hF);
    checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_out_data", 64'(out_data), 64'h0);
    checkOutput("rst_out_id", 64'(out_id), 64'h0);
    checkOutput("rst_err", 64'(err_grant), 64'h0);
`ifdef ARBQ_STATS_EN
    checkOutput("rst_pop_cnt", pop_cnt, 64'h0);
`endif

    // Single push and pop on requester 2
    applyStimulus(4'b0100, slot(2, 32'hA5A5_0002), 4'b0000);
    checkOutput("t1_req_after_push", 64'(req), 64'h4);
    expectPop(2, 32'hA5A5_0002);
    checkOutput("t1_req_after_pop", 64'(req), 64'h0);

    // Fill requester 0, refuse a fifth push, drain in order
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0001, slot(0, 32'h1000_0000 + k), 4'b0000);
    end
    checkOutput("t2_full_ready", 64'(in_ready[0]), 64'h0);
    applyStimulus(4'b0001, slot(0, 32'h0000_DEAD), 4'b0000);
    checkOutput("t2_refused_ready", 64'(in_ready[0]), 64'h0);
    expectPop(0, 32'h1000_0000);
    checkOutput("t2_ready_after_pop", 64'(in_ready[0]), 64'h1);
    for (int k = 1; k < 4; k++) begin
      expectPop(0, 32'h1000_0000 + k);
    end
    checkOutput("t2_req_drained", 64'(req), 64'h0);

    // Full requester 1: same-cycle push refused while the pop proceeds
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0010, slot(1, 32'h2000_0000 + k), 4'b0000);
    end
    sbq.push_back('{data: 32'h2000_0000, id: 2'd1});
    applyStimulus(4'b0010, slot(1, 32'h0000_0BAD), 4'b0010);
    checkOutput("t3_ready_count3", 64'(in_ready[1]), 64'h1);
    for (int k = 1; k < 4; k++) begin
      expectPop(1, 32'h2000_0000 + k);
    end
    checkOutput("t3_req_drained", 64'(req), 64'h0);

    // Requester 3 at two entries, simultaneous push and pop across pointer wrap
    applyStimulus(4'b1000, slot(3, 32'h3000_0000), 4'b0000);
    applyStimulus(4'b1000, slot(3, 32'h3000_0001), 4'b0000);
    for (int k = 0; k < 8; k++) begin
      sbq.push_back('{data: 32'h3000_0000 + k, id: 2'd3});
      applyStimulus(4'b1000, slot(3, 32'h3000_0002 + k), 4'b1000);
      checkOutput("t4_ready", 64'(in_ready[3]), 64'h1);
      checkOutput("t4_req", 64'(req[3]), 64'h1);
    end
    expectPop(3, 32'h3000_0008);
    checkOutput("t4_req_one_left", 64'(req[3]), 64'h1);
    expectPop(3, 32'h3000_0009);
    checkOutput("t4_req_drained", 64'(req), 64'h0);
    checkOutput("t4_err_clean", 64'(err_grant), 64'h0);

    // Grant errors and reset recovery
    applyStimulus(4'b0000, '0, 4'b0001);
    checkOutput("t5_err_empty_grant", 64'(err_grant), 64'h1);
    applyStimulus(4'b0011, slot(0, 32'h4000_0000) | slot(1, 32'h4100_0001), 4'b0000);
    checkOutput("t5_req_two", 64'(req), 64'h3);
    applyStimulus(4'b0000, '0, 4'b0011);
    checkOutput("t5_req_no_pop", 64'(req), 64'h3);
    checkOutput("t5_err_sticky", 64'(err_grant), 64'h1);
    checkOutput("t5_sb_drained", 64'(sbq.size()), 64'h0);
    rst = 1'b1;
    applyStimulus(4'b0000, '0, 4'b0010);
    rst = 1'b0;
    checkOutput("t5_err_cleared", 64'(err_grant), 64'h0);
    checkOutput("t5_req_cleared", 64'(req), 64'h0);
    checkOutput("t5_ready_all", 64'(in_ready), 64'hF);
    checkOutput("t5_out_valid", 64'(out_valid), 64'h0);

`ifdef ARBQ_STATS_EN
    checkOutput("t6_cnt_after_rst", pop_cnt, 64'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k < 2) ? 4'b1010 : 4'b0010,
                    slot(1, 32'h5100_0000 + k) | slot(3, 32'h5300_0000 + k), 4'b0000);
    end
    for (int k = 0; k < 4; k++) begin
      expectPop(1, 32'h5100_0000 + k);
    end
    expectPop(3, 32'h5300_0000);
    expectPop(3, 32'h5300_0001);
    applyStimulus(4'b0010, slot(1, 32'h5100_0004), 4'b0000);
    expectPop(1, 32'h5100_0004);
    checkOutput("t6_pop_cnt", pop_cnt, {16'd2, 16'd0, 16'd5, 16'd0});
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("final_sb_drained", 64'(sbq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
